eth_out_arb: RTL
================

ETH_OUT_ARB -- requirements
Module: eth_out_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width of every data port.
REQ-002 SHALL have parameter MAX_PKT_WORDS, default 64, longest legal packet in words (sop to eop inclusive).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 inDataA / inDataB  input  DATA_W  requester A/B data word.
REQ-007 inValidA / inValidB  input  1  word present on that requester.
REQ-008 inSopA / inSopB, inEopA / inEopB  input  1 each  start/end of packet, qualified by valid.
REQ-009 portAStall / portBStall  output  1  backpressure to requester; word not accepted while high.
REQ-010 outData  output  DATA_W  arbitrated output word.
REQ-011 outValid, outSop, outEop  output  1 each  output qualifiers.
REQ-012 outStall  input  1  downstream backpressure.
REQ-013 errTrunc  output  1  one-cycle pulse: packet force-terminated.

Function
REQ-014 SHALL arbitrate at packet granularity; a grant is never switched mid-packet.
REQ-015 FSM states IDLE, GRANT_A, GRANT_B; IDLE -> GRANT_x on accepted sop from x; GRANT_x -> IDLE on accepted eop or truncation.
REQ-016 Simultaneous sop on A and B in IDLE: round-robin; winner = port not granted last; after reset A wins first.
REQ-017 A word is accepted when valid high and its stall low; accepted word appears on out* one cycle later (latency 1, registered).
REQ-018 Non-granted port's stall SHALL be high in GRANT states; in IDLE stall low for a port presenting sop, high for the RR loser.
REQ-019 Valid word without sop in IDLE, or on non-granted port, SHALL be dropped (stall low) and not forwarded.
REQ-020 outStall high: out* held unchanged, both portAStall/portBStall high, no word accepted, word counter frozen.
REQ-021 Single-word packet (sop and eop same word) SHALL return to IDLE next cycle; back-to-back sop then accepted with no bubble.
REQ-022 Word counter 0..MAX_PKT_WORDS-1 per packet; accepting word MAX_PKT_WORDS without eop SHALL forward it with outEop forced high, pulse errTrunc, return to IDLE; remainder dropped per REQ-019.
REQ-023 Sop on the granted port mid-packet SHALL be forwarded as data with outSop low.
REQ-024 outValid low on any cycle with no accepted word (outStall low).

Reset
REQ-025 On reset: state IDLE, RR pointer favours A, counter 0, outValid/outSop/outEop/errTrunc 0, outData 0, portAStall/portBStall 0.
REQ-026 Reset mid-packet SHALL abandon the packet; no outEop emitted.

Configuration
REQ-027 With ETH_ARB_STATS_EN defined: outputs pktCntA/pktCntB (16 bits each) count forwarded eops per port, wrap at 0xFFFF->0, reset to 0; truncations also counted in errCnt (8 bits, saturating).
REQ-028 Without ETH_ARB_STATS_EN: those ports and counters absent; all other behaviour identical.

Structure
REQ-029 Package eth_arb_pkg SHALL hold the FSM state enum, the port-id typedef, and default DATA_W/MAX_PKT_WORDS constants.
REQ-030 Round-robin pointer and tie-break logic SHALL be sub-module eth_arb_rr; everything else in eth_out_arb.

Verification
REQ-031 Reset, then A sends 4-word packet 0xA0..0xA3 -> out shows same words cycle+1, outSop on 0xA0, outEop on 0xA3, portBStall never needed.
REQ-032 A and B assert sop same cycle after reset -> A forwarded first, portBStall high until A eop, then B packet with no idle cycle.
REQ-033 outStall high 3 cycles mid-packet -> out* frozen, both stalls high, no word lost or duplicated.
REQ-034 B sends 65 words no eop (MAX_PKT_WORDS=64) -> 64th word with outEop, errTrunc pulse once, rest dropped, next A packet forwarded.
REQ-035 Reset asserted on word 2 of 5-word packet -> all outputs 0 next cycle, next sop on B granted (pointer reset favours A, A idle).
REQ-036 ETH_ARB_STATS_EN: 3 A packets, 2 B packets, 1 truncation -> pktCntA=3, pktCntB=2, errCnt=1.

Source files
------------

// File: rtl/eth_arb_pkg.sv
// eth_arb_pkg -- shared types and default sizing for the Ethernet output arbiter.
package eth_arb_pkg;

  localparam int DEF_DATA_W        = 32;
  localparam int DEF_MAX_PKT_WORDS = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arbState_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } portId_t;

endpackage

// File: rtl/eth_arb_rr.sv
// eth_arb_rr -- round-robin tie-break between two packet requesters.
// winner is 0 for port A, 1 for port B. The pointer remembers the last port
// granted; after reset it points at B so that A wins the first tie.
module eth_arb_rr
  import eth_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic reqA,
  input  logic reqB,
  input  logic advance,
  output logic winner
);

  portId_t lastGrant;
  portId_t winnerId;

  // Pick the sole requester, or on a tie the port that was not granted last.
  always_comb begin
    winnerId = PORT_A;
    if (reqA && reqB) begin
      winnerId = (lastGrant == PORT_A) ? PORT_B : PORT_A;
    end else if (reqB) begin
      winnerId = PORT_B;
    end
  end

  assign winner = winnerId;

  // Record the winner whenever a packet is actually granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant <= PORT_B;
    end else if (advance) begin
      lastGrant <= winnerId;
    end
  end

endmodule

// File: rtl/eth_out_arb.sv
// eth_out_arb -- two-input, packet-granular output arbiter with registered
// output stage, downstream backpressure and oversize-packet truncation.
// Optional statistics counters are built when ETH_ARB_STATS_EN is defined.
//
// state   | meaning
// IDLE    | no packet open; accept a sop from either port (round-robin on tie)
// GRANT_A | packet from A open; B stalled until A eop or truncation
// GRANT_B | packet from B open; A stalled until B eop or truncation
module eth_out_arb
  import eth_arb_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_PKT_WORDS = DEF_MAX_PKT_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] inDataA,
  input  logic              inValidA,
  input  logic              inSopA,
  input  logic              inEopA,
  input  logic [DATA_W-1:0] inDataB,
  input  logic              inValidB,
  input  logic              inSopB,
  input  logic              inEopB,
  output logic              portAStall,
  output logic              portBStall,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  output logic              outSop,
  output logic              outEop,
  input  logic              outStall,
  output logic              errTrunc
`ifdef ETH_ARB_STATS_EN
  ,
  output logic [15:0]       pktCntA,
  output logic [15:0]       pktCntB,
  output logic [7:0]        errCnt
`endif
);

  localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_WORDS - 1);

  arbState_t         state, stateNext;
  logic [CNT_W-1:0]  wordCnt, cntNext;
  logic              sopReqA, sopReqB;
  logic              rrWinner;
  logic              rrAdvance;
  portId_t           curPort;
  logic [DATA_W-1:0] curData;
  logic              curEop;
  logic              fwd, fwdSop, fwdEop, trunc;

  assign sopReqA = inValidA && inSopA;
  assign sopReqB = inValidB && inSopB;

  eth_arb_rr uRr (
    .clk     (clk),
    .reset   (reset),
    .reqA    (sopReqA),
    .reqB    (sopReqB),
    .advance (rrAdvance),
    .winner  (rrWinner)
  );

  // Select which port's word is under consideration this cycle.
  always_comb begin
    case (state)
      GRANT_A: curPort = PORT_A;
      GRANT_B: curPort = PORT_B;
      default: curPort = portId_t'(rrWinner);
    endcase
  end

  assign curData = (curPort == PORT_A) ? inDataA : inDataB;
  assign curEop  = (curPort == PORT_A) ? inEopA  : inEopB;

  // Next-state, stall and forward decisions; nothing moves while downstream stalls.
  always_comb begin
    stateNext = state;
    cntNext   = wordCnt;
    portAStall = 1'b0;
    portBStall = 1'b0;
    fwd       = 1'b0;
    fwdSop    = 1'b0;
    fwdEop    = 1'b0;
    trunc     = 1'b0;
    rrAdvance = 1'b0;
    if (!reset) begin
      if (outStall) begin
        portAStall = 1'b1;
        portBStall = 1'b1;
      end else begin
        case (state)
          IDLE: begin
            // Only the tie loser is held; a non-sop word is taken and dropped.
            portAStall = sopReqA && sopReqB && (rrWinner == PORT_B);
            portBStall = sopReqA && sopReqB && (rrWinner == PORT_A);
            fwd        = sopReqA || sopReqB;
            fwdSop     = fwd;
            rrAdvance  = fwd;
          end
          GRANT_A: begin
            portBStall = 1'b1;
            fwd        = inValidA;
          end
          GRANT_B: begin
            portAStall = 1'b1;
            fwd        = inValidB;
          end
          default: stateNext = IDLE;
        endcase
        if (fwd) begin
          if (curEop) begin
            fwdEop    = 1'b1;
            stateNext = IDLE;
            cntNext   = '0;
          end else if (wordCnt == LAST_IDX) begin
            fwdEop    = 1'b1;
            trunc     = 1'b1;
            stateNext = IDLE;
            cntNext   = '0;
          end else begin
            stateNext = (curPort == PORT_A) ? GRANT_A : GRANT_B;
            cntNext   = wordCnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // State, word counter and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wordCnt  <= '0;
      outData  <= '0;
      outValid <= 1'b0;
      outSop   <= 1'b0;
      outEop   <= 1'b0;
      errTrunc <= 1'b0;
    end else begin
      state   <= stateNext;
      wordCnt <= cntNext;
      if (outStall) begin
        errTrunc <= 1'b0;
      end else begin
        outValid <= fwd;
        outSop   <= fwdSop;
        outEop   <= fwdEop;
        errTrunc <= trunc;
        if (fwd) begin
          outData <= curData;
        end
      end
    end
  end

`ifdef ETH_ARB_STATS_EN
  // Per-port packet counts (wrapping) and saturating truncation count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pktCntA <= '0;
      pktCntB <= '0;
      errCnt  <= '0;
    end else begin
      if (fwd && fwdEop) begin
        if (curPort == PORT_A) begin
          pktCntA <= pktCntA + 16'd1;
        end else begin
          pktCntB <= pktCntB + 16'd1;
        end
      end
      if (trunc && (errCnt != 8'hFF)) begin
        errCnt <= errCnt + 8'd1;
      end
    end
  end
`endif

endmodule
